// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle for pipe_stage_buf: upstream offer, downstream head and memory-response side channel.
interface pipe_stage_buf_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned LOAD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_memctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_memctrl;
    logic [LOAD_W-1:0] out_load;
    logic              mem_hit;
    logic [LOAD_W-1:0] mem_load;

    // Environment side: offers entries, accepts the head, returns memory responses.
    modport master (
        output in_valid, in_data, in_memctrl, out_ready, mem_hit, mem_load,
        input  in_ready, out_valid, out_data, out_memctrl, out_load
    );

    // Stage side.
    modport slave (
        input  in_valid, in_data, in_memctrl, out_ready, mem_hit, mem_load,
        output in_ready, out_valid, out_data, out_memctrl, out_load
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with a 2-entry skid buffer and a head-entry memory-response capture.
// in_ready comes from registered skid state only, so downstream ready never reaches upstream combinationally.
module pipe_stage_buf #(
    parameter int unsigned       DATA_W      = 128,
    parameter int unsigned       CTRL_W      = 4,
    parameter logic [CTRL_W-1:0] MEMCLR_MASK = CTRL_W'(4'b0011),
    parameter int unsigned       LOAD_W      = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 flush,
    pipe_stage_buf_if.slave      bus,
    output logic [1:0]           occupancy,
    output logic                 hit_err
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] memctrl;
        logic [LOAD_W-1:0] load;
    } entry_t;

    entry_t head_q, head_n;
    entry_t skid_q, skid_n;
    entry_t new_entry;
    logic   hit_err_n;
    logic   accept;
    logic   depart;
    logic   hit_take;

    assign bus.in_ready    = !skid_q.valid && !RST;
    assign bus.out_valid   = head_q.valid;
    assign bus.out_data    = head_q.data;
    assign bus.out_memctrl = head_q.memctrl;
    assign bus.out_load    = head_q.load;

    assign accept    = bus.in_valid && bus.in_ready;
    assign depart    = head_q.valid && bus.out_ready;
    // A response is only meaningful for a head that stays put and still has request bits pending.
    assign hit_take  = bus.mem_hit && head_q.valid && !depart
                       && ((head_q.memctrl & MEMCLR_MASK) != '0);

    always_comb begin
        new_entry.valid   = 1'b1;
        new_entry.data    = bus.in_data;
        new_entry.memctrl = bus.in_memctrl;
        new_entry.load    = '0;
    end

    // Next-state for head, skid and the sticky dropped-hit flag.
    always_comb begin
        head_n    = head_q;
        skid_n    = skid_q;
        hit_err_n = hit_err;

        if (flush) begin
            head_n.valid = 1'b0;
            skid_n.valid = 1'b0;
        end else begin
            if (!head_q.valid || (depart && !skid_q.valid)) begin
                if (accept) begin
                    head_n = new_entry;
                end else begin
                    head_n.valid = 1'b0;
                end
            end else if (depart) begin
                head_n       = skid_q;
                skid_n.valid = 1'b0;
            end else begin
                if (accept) begin
                    skid_n = new_entry;
                end
                if (hit_take) begin
                    head_n.load    = bus.mem_load;
                    head_n.memctrl = head_q.memctrl & ~MEMCLR_MASK;
                end
            end

            if (bus.mem_hit && !hit_take) begin
                hit_err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q    <= '0;
            skid_q    <= '0;
            occupancy <= 2'd0;
            hit_err   <= 1'b0;
        end else begin
            head_q    <= head_n;
            skid_q    <= skid_n;
            occupancy <= 2'({1'b0, head_n.valid} + {1'b0, skid_n.valid});
            hit_err   <= hit_err_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, skid fill/drain, memory hits, flush and reset.
module tb_pipe_stage_buf;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned LOAD_W = 32;

    logic       CLK;
    logic       RST;
    logic       flush;
    logic [1:0] occupancy;
    logic       hit_err;

    int n_checks;
    int n_errors;

    pipe_stage_buf_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .LOAD_W(LOAD_W)) bus ();

    pipe_stage_buf #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .MEMCLR_MASK(4'b0011),
        .LOAD_W     (LOAD_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .bus      (bus),
        .occupancy(occupancy),
        .hit_err  (hit_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic offer(input logic [127:0] d, input logic [3:0] ctrl);
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_memctrl = ctrl;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_memctrl = '0;
        bus.out_ready = 1'b0;
        bus.mem_hit = 1'b0;
        bus.mem_load = '0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_data", bus.out_data, 128'd0);
        check("rst_occ", 128'(occupancy), 128'd0);
        check("rst_hit_err", 128'(hit_err), 128'd0);
        RST = 1'b0;
        #1;
        check("rel_in_ready", 128'(bus.in_ready), 128'd1);

        // Back-to-back streaming with out_ready high
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(128'(i), 4'b0000);
            tick();
            check("stream_valid", 128'(bus.out_valid), 128'd1);
            check("stream_data", bus.out_data, 128'(i));
            check("stream_occ", 128'(occupancy), 128'd1);
            check("stream_in_ready", 128'(bus.in_ready), 128'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_drained", 128'(bus.out_valid), 128'd0);
        check("stream_occ0", 128'(occupancy), 128'd0);

        // Skid fill with downstream stalled, then drain in order
        bus.out_ready = 1'b0;
        offer(128'hA, 4'b0000);
        tick();
        offer(128'hB, 4'b0000);
        tick();
        check("skid_occ2", 128'(occupancy), 128'd2);
        check("skid_in_ready", 128'(bus.in_ready), 128'd0);
        check("skid_head_a", bus.out_data, 128'hA);
        offer(128'hC, 4'b0000);
        tick();
        check("skid_hold_a", bus.out_data, 128'hA);
        check("skid_hold_occ", 128'(occupancy), 128'd2);
        bus.out_ready = 1'b1;
        tick();
        check("drain_b", bus.out_data, 128'hB);
        check("drain_b_valid", 128'(bus.out_valid), 128'd1);
        check("drain_b_occ", 128'(occupancy), 128'd1);
        tick();
        check("drain_c", bus.out_data, 128'hC);
        check("drain_c_valid", 128'(bus.out_valid), 128'd1);
        bus.in_valid = 1'b0;
        tick();
        check("drain_empty", 128'(bus.out_valid), 128'd0);

        // Memory hit on a stalled head, then a second hit that must be dropped
        bus.out_ready = 1'b0;
        offer(128'h33, 4'b1011);
        tick();
        bus.in_valid = 1'b0;
        bus.mem_hit = 1'b1;
        bus.mem_load = 32'hDEADBEEF;
        tick();
        check("hit_ctrl", 128'(bus.out_memctrl), 128'h8);
        check("hit_load", 128'(bus.out_load), 128'hDEADBEEF);
        check("hit_no_err", 128'(hit_err), 128'd0);
        bus.mem_load = 32'h12345678;
        tick();
        check("hit2_err", 128'(hit_err), 128'd1);
        check("hit2_ctrl", 128'(bus.out_memctrl), 128'h8);
        check("hit2_load", 128'(bus.out_load), 128'hDEADBEEF);
        check("hit2_data", bus.out_data, 128'h33);
        bus.mem_hit = 1'b0;

        // Clear hit_err, then hit coincident with a departing head
        RST = 1'b1;
        tick();
        RST = 1'b0;
        offer(128'h44, 4'b0011);
        tick();
        offer(128'h55, 4'b0001);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.mem_hit = 1'b1;
        bus.mem_load = 32'h0000CAFE;
        tick();
        check("dep_hit_err", 128'(hit_err), 128'd1);
        check("dep_next_data", bus.out_data, 128'h55);
        check("dep_next_load", 128'(bus.out_load), 128'd0);
        check("dep_next_ctrl", 128'(bus.out_memctrl), 128'h1);
        bus.mem_hit = 1'b0;
        tick();
        check("dep_empty", 128'(bus.out_valid), 128'd0);

        // Flush with a same-cycle offer
        bus.out_ready = 1'b0;
        offer(128'h66, 4'b0000);
        tick();
        offer(128'h77, 4'b0000);
        tick();
        check("pre_flush_occ", 128'(occupancy), 128'd2);
        offer(128'h88, 4'b0000);
        flush = 1'b1;
        tick();
        check("flush_valid", 128'(bus.out_valid), 128'd0);
        check("flush_occ", 128'(occupancy), 128'd0);
        check("flush_in_ready", 128'(bus.in_ready), 128'd1);
        check("flush_hit_err", 128'(hit_err), 128'd1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("flush_no_ghost", 128'(bus.out_valid), 128'd0);

        // Reset with a full buffer and hit_err set
        offer(128'h99, 4'b0011);
        tick();
        offer(128'hAA, 4'b0000);
        tick();
        bus.in_valid = 1'b0;
        check("full_occ", 128'(occupancy), 128'd2);
        RST = 1'b1;
        #1;
        check("rst2_in_ready_comb", 128'(bus.in_ready), 128'd0);
        tick();
        check("rst2_valid", 128'(bus.out_valid), 128'd0);
        check("rst2_data", bus.out_data, 128'd0);
        check("rst2_ctrl", 128'(bus.out_memctrl), 128'd0);
        check("rst2_load", 128'(bus.out_load), 128'd0);
        check("rst2_occ", 128'(occupancy), 128'd0);
        check("rst2_hit_err", 128'(hit_err), 128'd0);
        check("rst2_in_ready", 128'(bus.in_ready), 128'd0);
        RST = 1'b0;
        #1;
        check("rel2_in_ready", 128'(bus.in_ready), 128'd1);
        tick();
        check("rel2_valid", 128'(bus.out_valid), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register. Successor to the fixed EX/MEM latch.
- Carries an opaque payload plus a memory-control field between stages, using valid/ready flow control in place of global ihit stalls.
- A 2-entry skid buffer keeps the registered in_ready timing-clean; it has no combinational ready path from downstream.
- A memory-response side channel captures load data into the head entry and retires that entry's memory request bits. This generalises the old dhit behaviour.

Parameters:
- DATA_W, 128, payload width (aluout, dest, imm, npc, instr, etc. packed by the instantiator).
- CTRL_W, 4, memory-control field width.
- MEMCLR_MASK, 4'b0011, CTRL bits cleared on a memory hit; width is CTRL_W.
- LOAD_W, 32, load-data width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  upstream entry offered.
- in_ready  out  1  stage can accept an entry.
- in_data  in  DATA_W  upstream payload.
- in_memctrl  in  CTRL_W  upstream memory control.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_W  head payload.
- out_memctrl  out  CTRL_W  head memory control (after hit clearing).
- out_load  out  LOAD_W  captured load data for head.
- mem_hit  in  1  memory response for head entry.
- mem_load  in  LOAD_W  response data.
- occupancy  out  2  number of valid entries, 0..2.
- hit_err  out  1  sticky: a mem_hit was dropped.

Behaviour:
- Storage:
  - Head register (drives the out_* ports) and skid register, each holding {valid, data, memctrl, load}.
  - A new entry's load field is initialised to 0.
- in_ready = !skid_valid && !RST. It depends on registered state only.
- Transfers:
  - Accept = in_valid && in_ready.
  - Depart = out_valid && out_ready.
- Per-cycle update, at equal priority within the "else" branch:
  - Head empty, or departing with skid empty: head <= incoming entry if accepted, else head.valid <= 0.
  - Departing with skid valid: head <= skid, skid.valid <= 0. in_ready is 0 this cycle, so nothing is accepted.
  - Head valid, not departing, accept: skid <= incoming entry. in_ready drops the next cycle.
  - Order is preserved (FIFO). No entry is lost or duplicated.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Full throughput is 1 entry per cycle with out_ready held high.
- Memory hit:
  - Applies only when out_valid && !out_ready... more precisely, only when the head is valid, not departing, and (out_memctrl & MEMCLR_MASK) != 0.
  - Effect: out_load <= mem_load; out_memctrl <= out_memctrl & ~MEMCLR_MASK. Payload is unchanged.
  - Any other mem_hit is discarded and sets hit_err <= 1.
  - mem_hit never affects the skid entry.
- flush:
  - Head.valid <= 0 and skid.valid <= 0. Any same-cycle accept or hit is discarded, and no hit_err is raised.
  - Data fields hold their last values. out_valid = 0 the next cycle; in_ready = 1.
- Reset:
  - Priority: RST > flush > normal operation.
  - On RST, every output register clears: out_valid 0, out_data 0, out_memctrl 0, out_load 0, occupancy 0, hit_err 0, skid cleared.
  - in_ready is 0 while RST is high and 1 the cycle after release.
  - A reset mid-operation drops all entries with no drain.
- occupancy = head.valid + skid.valid, registered.
- hit_err clears only on RST.

Test Plan:
- Reset, then 4 back-to-back entries (data 1..4, memctrl 0) with out_ready=1 -> out_valid from cycle 1; out_data 1,2,3,4 on consecutive cycles; occupancy ≤1; in_ready stays 1.
- Entries A, B, C sent with out_ready=0 -> A is in head and B in skid; occupancy=2; in_ready=0; C is held upstream. Raise out_ready -> outputs A, B, C in order with no gaps after the first.
- Head memctrl=4'b1011, mem_hit=1, mem_load=32'hDEADBEEF, out_ready=0 -> next cycle out_memctrl=4'b1000 and out_load=DEADBEEF; a second mem_hit -> hit_err=1 and state unchanged.
- mem_hit in the same cycle as a departing head -> hit dropped; hit_err=1; next head's out_load=0.
- Two entries buffered, then flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1; the offered entry does not appear.
- Full buffer, hit_err=1, assert RST for 1 cycle -> all outputs zero and in_ready=0 during reset; in_ready=1 the cycle after release.
